bnn_input_loader: RTL
=====================

# bnn_input_loader

Input-side front end of `tt_um_bnn_classifier`. It receives the binarized feature vector one byte at a time from the off-chip host over the dedicated input pins, using an asynchronous strobe and clear on the bidirectional pins. It assembles the full vector, hands it to the classifier core with a one-cycle start pulse, and paces the host through a ready flag on the output pins. This is the device end of the byte-load protocol that the host and testbench drive.

## Interface
- `FEAT_BYTES`, default 8: feature vector length in bytes (64 binary features).
- `SYNC_STAGES`, default 2: synchronizer depth on `host_strobe` and `host_clear`; minimum 2.
- `CW`, derived `$clog2(FEAT_BYTES)`: byte counter width.

Ports:
- `clk`  in  1  single design clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ena`  in  1  design enable; when low, strobe edges are ignored and all state holds.
- `host_data`  in  8  feature byte, driven from `ui_in`; host holds it stable around the strobe.
- `host_strobe`  in  1  asynchronous byte strobe from `uio_in[0]`; each rising edge delivers one byte.
- `host_clear`  in  1  asynchronous clear from `uio_in[1]`; active-high level.
- `core_busy`  in  1  classifier core busy flag.
- `feat_vec`  out  8*FEAT_BYTES  assembled vector; byte *i* occupies bits [8i+7:8i].
- `feat_valid`  out  1  one-cycle start pulse to the core.
- `byte_count`  out  CW  index of the next byte slot to be written.
- `overrun`  out  1  sticky error: a byte arrived while the loader was not in LOAD.
- `loader_ready`  out  1  high when the loader accepts bytes; routed to `uo_out`.

## Operation
- `host_strobe` and `host_clear` each pass through a SYNC_STAGES flop chain. A delayed copy of the synchronized strobe gives a rising-edge pulse `edge = s & ~s_d`. The delayed copy updates even while `ena` is low, so no spurious edge appears on re-enable.
- The FSM has three states: LOAD, ISSUE and WAIT. The reset state is LOAD.
- **LOAD:** on `edge & ena`, write `host_data` into slot `byte_count` and increment `byte_count`. On the write to slot FEAT_BYTES-1, `byte_count` wraps to 0 and the FSM moves to ISSUE.
- **ISSUE:** lasts exactly one cycle, with `feat_valid`=1. Next state is WAIT.
- **WAIT:**
  - The first WAIT cycle ignores `core_busy`, because the core raises it the cycle after `feat_valid`.
  - From the second cycle on, the first cycle with `core_busy`=0 returns the FSM to LOAD.
- **Overrun:** `edge & ena` in ISSUE or WAIT sets `overrun`. The byte is discarded, and `feat_vec` and `byte_count` are unchanged.
- **Clear:** a synchronized `host_clear` high (with `ena` high) forces the following, from any state:
  - state goes to LOAD;
  - `byte_count`, `feat_vec` and `overrun` go to 0;
  - `feat_valid` goes to 0 in the next cycle.
- **Clear priority:** clear wins over a simultaneous edge. A last-byte edge coinciding with clear produces no write and no `feat_valid`.
- `loader_ready` = (state==LOAD) & ~clear_sync, combinational from registers.
- `feat_vec` holds its value after ISSUE. The next load overwrites it byte by byte from slot 0.

## Timing
- **Reset values:** `feat_vec`=0, `feat_valid`=0, `byte_count`=0, `overrun`=0, state LOAD, so `loader_ready`=1. All synchronizer flops are 0.
- **Reset mid-operation:** takes effect immediately and asynchronously; there is no partial-vector carry-over.
- **Write latency:** let E0 be the first clock edge that samples `host_strobe` high. The byte is written at edge E0+SYNC_STAGES, and `byte_count` updates at the same edge.
- **Start latency:** for the last byte, `feat_valid` is high during the cycle after edge E0+SYNC_STAGES, for exactly one cycle.
- **Host rules:**
  - `host_data` stable from one cycle before the strobe rises through E0+SYNC_STAGES.
  - Strobe high for ≥SYNC_STAGES+1 cycles and low for ≥SYNC_STAGES+1 cycles.
  - Wait for `loader_ready` before starting a new vector.
- **Clear latency:** `host_clear` sampled high at edge C0 takes effect at edge C0+SYNC_STAGES. `loader_ready` is low while the synchronized clear is high.
- **Sustained rate:** one byte per 2·(SYNC_STAGES+1) cycles.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, `ena`=1. Expect `feat_vec`=0, `byte_count`=0, `feat_valid`=0, `overrun`=0, `loader_ready`=1.
- **Full load:** strobe bytes 0x01…0x08 with `core_busy` pulsed high for 10 cycles after start.
  - Expect `feat_vec`=0x0807060504030201 and `byte_count`=0.
  - Expect exactly one `feat_valid` cycle at E0+SYNC_STAGES+1 of the last byte.
  - Expect `loader_ready` back to 1 when `core_busy` drops.
- **Overrun:** after a full load, hold `core_busy`=1 and strobe 0xAA. Expect `overrun`=1, `feat_vec` unchanged and `loader_ready`=0. After `core_busy`=0, expect `loader_ready`=1 with `overrun` still 1.
- **Clear mid-load:** strobe 0x11, 0x22, 0x33, then pulse `host_clear`.
  - Expect `byte_count`=0, `feat_vec`=0, `overrun`=0.
  - A fresh 8-byte load 0xF0…0xF7 then yields a correct vector and one `feat_valid`.
  - Also drive clear coincident with the last-byte edge: expect no `feat_valid`.
- **ENA gating:** with `ena`=0, strobe 4 bytes: expect `byte_count`=0. Raise `ena` while `host_strobe` is already high: expect no write. The next rising strobe writes slot 0.
- **Async reset mid-load:** after 5 bytes, drop `rst_n` between clock edges. All outputs must read reset values before the next edge, and a full 8-byte load afterwards must be correct.

Source files
------------

// File: rtl/bnn_input_loader.sv
// bnn_input_loader: byte-serial feature loader for the BNN classifier.
// Synchronizes host strobe/clear, assembles the vector, pulses start.
module bnn_input_loader #(
  parameter int FEAT_BYTES  = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(FEAT_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              host_data,
  input  logic                    host_strobe,
  input  logic                    host_clear,
  input  logic                    core_busy,
  output logic [8*FEAT_BYTES-1:0] feat_vec,
  output logic                    feat_valid,
  output logic [CW-1:0]           byte_count,
  output logic                    overrun,
  output logic                    loader_ready
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(FEAT_BYTES - 1);

  state_t               state;
  logic                 wait_first;
  logic [SYNC_STAGES-1:0] stb_q;
  logic [SYNC_STAGES-1:0] clr_q;
  logic                 stb_d;
  logic                 stb_s;
  logic                 clr_s;
  logic                 stb_edge;

  assign stb_s    = stb_q[SYNC_STAGES-1];
  assign clr_s    = clr_q[SYNC_STAGES-1];
  assign stb_edge = stb_s & ~stb_d & ena;

  // Synchronizers run regardless of ena so re-enable sees no stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= '0;
      clr_q <= '0;
      stb_d <= 1'b0;
    end else begin
      stb_q <= {stb_q[SYNC_STAGES-2:0], host_strobe};
      clr_q <= {clr_q[SYNC_STAGES-2:0], host_clear};
      stb_d <= stb_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      wait_first <= 1'b0;
      feat_vec   <= '0;
      feat_valid <= 1'b0;
      byte_count <= '0;
      overrun    <= 1'b0;
    end else if (ena) begin
      feat_valid <= 1'b0;
      if (clr_s) begin
        state      <= S_LOAD;
        wait_first <= 1'b0;
        feat_vec   <= '0;
        byte_count <= '0;
        overrun    <= 1'b0;
      end else begin
        unique case (state)
          S_LOAD: begin
            if (stb_edge) begin
              feat_vec[int'(byte_count)*8 +: 8] <= host_data;
              if (byte_count == LAST) begin
                byte_count <= '0;
                state      <= S_ISSUE;
                feat_valid <= 1'b1;
              end else begin
                byte_count <= byte_count + CW'(1);
              end
            end
          end
          S_ISSUE: begin
            state      <= S_WAIT;
            wait_first <= 1'b1;
            if (stb_edge) overrun <= 1'b1;
          end
          S_WAIT: begin
            if (stb_edge) overrun <= 1'b1;
            // core raises busy one cycle late, so skip the first look
            if (wait_first) wait_first <= 1'b0;
            else if (!core_busy) state <= S_LOAD;
          end
          default: state <= S_LOAD;
        endcase
      end
    end
  end

  assign loader_ready = (state == S_LOAD) & ~clr_s;

endmodule
